battle_grid_controller: RTL and testbench

//  Parametrised battleship game core for a COLS x ROWS LED grid: preset fleet selection, fleet save,

---
 rtl/battle_pkg.sv | 29 ++
 rtl/grid_scan.sv | 55 +++++
 rtl/battle_grid_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_battle_grid_controller.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/battle_pkg.sv
// Shared types and helpers for the battleship grid controller: state encoding,
// the preset fleet formula and a cell popcount.
package battle_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PLACE  = 3'd1,
    ST_ATTACK = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4
  } state_e;

  // Widest grid supported (16 x 16); popcount operates on this width.
  localparam int MAX_CELLS = 256;

  function automatic logic preset_cell(input int p, input int c, input int r, input int rows);
    return ((c * rows + r) % (p + 3)) == 0;
  endfunction

  function automatic int popcount(input logic [MAX_CELLS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_CELLS; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/grid_scan.sv
// Column scanner for the LED matrix: advances one column per scan_tick and
// registers the one-hot column select plus the row bits of that column.
module grid_scan #(
  parameter int COLS = 5,
  parameter int ROWS = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 scan_tick,
  input  logic [COLS*ROWS-1:0] frame,
  output logic [COLS-1:0]      columns,
  output logic [ROWS-1:0]      lines,
  output logic                 frame_wrap
);

  localparam int CW = $clog2(COLS);

  logic [CW-1:0]   col_q, col_d;
  logic [COLS-1:0] columns_q, columns_d;
  logic [ROWS-1:0] lines_q, lines_d;

  assign frame_wrap = scan_tick && (col_q == CW'(COLS - 1));

  // Row data is refreshed every cycle so the display follows game changes between ticks.
  always_comb begin
    col_d = col_q;
    if (scan_tick) begin
      col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    end
    columns_d = '0;
    lines_d   = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_d == CW'(c)) begin
        columns_d[c] = 1'b1;
        lines_d      = frame[c*ROWS +: ROWS];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q     <= '0;
      columns_q <= COLS'(1);
      lines_q   <= '0;
    end else begin
      col_q     <= col_d;
      columns_q <= columns_d;
      lines_q   <= lines_d;
    end
  end

  assign columns = columns_q;
  assign lines   = lines_q;

endmodule

// File: rtl/battle_grid_controller.sv
// Battleship game core: fleet presets, attack resolution, shot budget, win/lose and matrix drive.
// Optional feature macro BLINK_MISS_EN: missed cells blink on the display during the attack phase.
module battle_grid_controller #(
  parameter int COLS        = 5,
  parameter int ROWS        = 7,
  parameter int MAX_SHOTS   = 15,
  parameter int NUM_PRESETS = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             scan_tick,
  input  logic                             on_off,
  input  logic                             status,
  input  logic                             change_btn,
  input  logic                             save_btn,
  input  logic                             reset_game_btn,
  input  logic                             attack_btn,
  input  logic [$clog2(COLS)-1:0]          col_attack,
  input  logic [$clog2(ROWS)-1:0]          row_attack,
  output logic [COLS-1:0]                  columns,
  output logic [ROWS-1:0]                  lines,
  output logic [2:0]                       game_state,
  output logic [$clog2(MAX_SHOTS+1)-1:0]   shots_used,
  output logic [$clog2(COLS*ROWS+1)-1:0]   ships_left,
  output logic                             hit_pulse,
  output logic                             miss_pulse,
  output logic                             dup_pulse,
  output logic                             invalid_pulse
);

  import battle_pkg::*;

  localparam int NC  = COLS * ROWS;
  localparam int IW  = $clog2(NC);
  localparam int SHW = $clog2(MAX_SHOTS + 1);
  localparam int SW  = $clog2(NC + 1);
  localparam int PW  = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   preset_q, preset_d;
  logic            saved_q, saved_d;
  logic [NC-1:0]   ship_q, ship_d;
  logic [NC-1:0]   shot_q, shot_d;
  logic [SHW-1:0]  shots_q, shots_d;
  logic [SW-1:0]   ships_q, ships_d;
  logic            hit_q, hit_d, miss_q, miss_d, dup_q, dup_d, inv_q, inv_d;
  logic [3:0]      btn_prev_q, btn_prev_d;
  logic [3:0]      btn_now, btn_edge;
  logic [NC-1:0]   preset_pat;
  logic [NC-1:0]   frame;
  logic [IW-1:0]   idx;
  logic            target_ok;
  logic            frame_wrap;

  // Button order: {change, save, reset_game, attack}.
  assign btn_now    = {change_btn, save_btn, reset_game_btn, attack_btn};
  assign btn_edge   = btn_now & ~btn_prev_q;
  assign btn_prev_d = btn_now;

  assign target_ok = (int'(col_attack) < COLS) && (int'(row_attack) < ROWS);
  assign idx       = IW'(col_attack) * IW'(ROWS) + IW'(row_attack);

  always_comb begin
    preset_pat = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        preset_pat[c*ROWS + r] = preset_cell(int'(preset_q), c, r, ROWS);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    saved_d  = saved_q;
    ship_d   = ship_q;
    shot_d   = shot_q;
    shots_d  = shots_q;
    ships_d  = ships_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    dup_d    = 1'b0;
    inv_d    = 1'b0;
    if (!on_off) begin
      state_d = ST_OFF;
    end else if (state_q == ST_OFF) begin
      state_d = ST_PLACE;
      saved_d = 1'b0;
      shot_d  = '0;
    end else if (btn_edge[1]) begin
      // Restart beats a same-cycle attack; the fleet preset survives.
      state_d = ST_PLACE;
      saved_d = 1'b0;
      shot_d  = '0;
      shots_d = '0;
      ships_d = '0;
    end else begin
      case (state_q)
        ST_PLACE: begin
          if (btn_edge[3]) begin
            preset_d = (preset_q == PW'(NUM_PRESETS - 1)) ? '0 : preset_q + 1'b1;
            saved_d  = 1'b0;
          end else if (btn_edge[2]) begin
            ship_d  = preset_pat;
            ships_d = SW'(popcount(MAX_CELLS'(preset_pat)));
            shots_d = '0;
            shot_d  = '0;
            saved_d = 1'b1;
          end else if (status && saved_q) begin
            state_d = ST_ATTACK;
          end
        end
        ST_ATTACK: begin
          if (btn_edge[0] && status) begin
            if (!target_ok) begin
              inv_d = 1'b1;
            end else if (shot_q[idx]) begin
              dup_d = 1'b1;
            end else begin
              shot_d[idx] = 1'b1;
              shots_d     = shots_q + 1'b1;
              if (ship_q[idx]) begin
                hit_d   = 1'b1;
                ships_d = ships_q - 1'b1;
              end else begin
                miss_d = 1'b1;
              end
              if (ships_d == '0) begin
                state_d = ST_WIN;
              end else if (shots_d == SHW'(MAX_SHOTS)) begin
                state_d = ST_LOSE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BLINK_MISS_EN
  logic [5:0] blink_cnt_q, blink_cnt_d;
  logic       blink_on_q, blink_on_d;

  // Phase flips after every 64 full scan frames and restarts lit on each attack entry.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (state_d == ST_ATTACK && state_q != ST_ATTACK) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (frame_wrap) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      if (blink_cnt_q == 6'd63) begin
        blink_on_d = ~blink_on_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`else
  logic unused_wrap;
  assign unused_wrap = frame_wrap;
`endif

  always_comb begin
    frame = '0;
    case (state_q)
      ST_PLACE:  frame = preset_pat;
      ST_ATTACK: begin
        frame = ship_q & shot_q;
`ifdef BLINK_MISS_EN
        if (blink_on_q) begin
          frame = frame | (shot_q & ~ship_q);
        end
`endif
      end
      ST_WIN:    frame = '1;
      ST_LOSE:   frame = ship_q;
      default:   frame = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_OFF;
      preset_q   <= '0;
      saved_q    <= 1'b0;
      ship_q     <= '0;
      shot_q     <= '0;
      shots_q    <= '0;
      ships_q    <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      dup_q      <= 1'b0;
      inv_q      <= 1'b0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      saved_q    <= saved_d;
      ship_q     <= ship_d;
      shot_q     <= shot_d;
      shots_q    <= shots_d;
      ships_q    <= ships_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      dup_q      <= dup_d;
      inv_q      <= inv_d;
      btn_prev_q <= btn_prev_d;
    end
  end

  grid_scan #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_grid_scan (
    .clock      (clock),
    .reset      (reset),
    .scan_tick  (scan_tick),
    .frame      (frame),
    .columns    (columns),
    .lines      (lines),
    .frame_wrap (frame_wrap)
  );

  assign game_state    = state_q;
  assign shots_used    = shots_q;
  assign ships_left    = ships_q;
  assign hit_pulse     = hit_q;
  assign miss_pulse    = miss_q;
  assign dup_pulse     = dup_q;
  assign invalid_pulse = inv_q;

endmodule

// File: tb/tb_battle_grid_controller.sv
// Scoreboard bench for battle_grid_controller with the default 5 x 7 grid, 15 shots, 4 presets.
module tb_battle_grid_controller;

  logic       clock;
  logic       reset;
  logic       scan_tick;
  logic       on_off;
  logic       status;
  logic       change_btn;
  logic       save_btn;
  logic       reset_game_btn;
  logic       attack_btn;
  logic [2:0] col_attack;
  logic [2:0] row_attack;
  logic [4:0] columns;
  logic [6:0] lines;
  logic [2:0] game_state;
  logic [3:0] shots_used;
  logic [5:0] ships_left;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       dup_pulse;
  logic       invalid_pulse;

  battle_grid_controller #(
    .COLS        (5),
    .ROWS        (7),
    .MAX_SHOTS   (15),
    .NUM_PRESETS (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .scan_tick      (scan_tick),
    .on_off         (on_off),
    .status         (status),
    .change_btn     (change_btn),
    .save_btn       (save_btn),
    .reset_game_btn (reset_game_btn),
    .attack_btn     (attack_btn),
    .col_attack     (col_attack),
    .row_attack     (row_attack),
    .columns        (columns),
    .lines          (lines),
    .game_state     (game_state),
    .shots_used     (shots_used),
    .ships_left     (ships_left),
    .hit_pulse      (hit_pulse),
    .miss_pulse     (miss_pulse),
    .dup_pulse      (dup_pulse),
    .invalid_pulse  (invalid_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] pulses;
    int         shots;
    int         ships;
    int         state;
  } exp_t;

  exp_t        sb_q[$];
  int          total;
  int          bad;
  logic [34:0] m_ship;
  logic [34:0] m_shot;
  int          m_shots;
  int          m_ships;
  int          m_state;
  int          sc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] bpat(input int p);
    logic [34:0] v;
    for (int k = 0; k < 35; k++) v[k] = ((k % (p + 3)) == 0);
    return v;
  endfunction

  function automatic logic [31:0] pulse_vec();
    return {28'd0, hit_pulse, miss_pulse, dup_pulse, invalid_pulse};
  endfunction

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_pulses"}, pulse_vec(), {28'd0, e.pulses});
      check({tag, "_shots"}, 32'(shots_used), 32'(e.shots));
      check({tag, "_ships"}, 32'(ships_left), 32'(e.ships));
      check({tag, "_state"}, 32'(game_state), 32'(e.state));
    end
  endtask

  task automatic fire(input string tag, input int c, input int r);
    exp_t e;
    int   k;
    e.pulses = 4'b0000;
    if (m_state == 2) begin
      if (c >= 5 || r >= 7) begin
        e.pulses = 4'b0001;
      end else begin
        k = c * 7 + r;
        if (m_shot[k]) begin
          e.pulses = 4'b0010;
        end else begin
          m_shot[k] = 1'b1;
          m_shots++;
          if (m_ship[k]) begin
            e.pulses = 4'b1000;
            m_ships--;
          end else begin
            e.pulses = 4'b0100;
          end
          if (m_ships == 0) m_state = 3;
          else if (m_shots == 15) m_state = 4;
        end
      end
    end
    e.shots = m_shots;
    e.ships = m_ships;
    e.state = m_state;
    @(negedge clock);
    col_attack = 3'(c);
    row_attack = 3'(r);
    attack_btn = 1'b1;
    sb_q.push_back(e);
    @(negedge clock);
    sb_check(tag);
    attack_btn = 1'b0;
    @(negedge clock);
    check({tag, "_clr"}, pulse_vec(), 32'd0);
  endtask

  task automatic press(input int which);
    @(negedge clock);
    case (which)
      0: change_btn = 1'b1;
      1: save_btn = 1'b1;
      default: reset_game_btn = 1'b1;
    endcase
    @(negedge clock);
    change_btn = 1'b0;
    save_btn = 1'b0;
    reset_game_btn = 1'b0;
    @(negedge clock);
  endtask

  task automatic model_restart();
    m_state = 1;
    m_shots = 0;
    m_ships = 0;
    m_shot  = '0;
  endtask

  task automatic model_save(input int p);
    m_ship  = bpat(p);
    m_ships = 0;
    for (int k = 0; k < 35; k++) m_ships += {31'd0, m_ship[k]};
    m_shots = 0;
    m_shot  = '0;
  endtask

  task automatic scan_check(input string tag, input logic [34:0] f);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      scan_tick = 1'b1;
      @(negedge clock);
      scan_tick = 1'b0;
      sc = (sc + 1) % 5;
      check({tag, "_col"}, 32'(columns), 32'(5'(1) << sc));
      check({tag, "_lines"}, 32'(lines), 32'((f >> (sc * 7)) & 35'h7f));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int miss_list[15];
    total = 0;
    bad = 0;
    sc = 0;
    reset = 1'b0;
    scan_tick = 1'b0;
    on_off = 1'b0;
    status = 1'b0;
    change_btn = 1'b0;
    save_btn = 1'b0;
    reset_game_btn = 1'b0;
    attack_btn = 1'b0;
    col_attack = '0;
    row_attack = '0;
    m_ship = '0;
    m_shot = '0;
    m_shots = 0;
    m_ships = 0;
    m_state = 0;
    miss_list = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14, 16, 17, 19, 20, 22};

    repeat (2) @(negedge clock);
    check("rst_state", 32'(game_state), 32'd0);
    check("rst_cols", 32'(columns), 32'd1);
    check("rst_lines", 32'(lines), 32'd0);
    check("rst_shots", 32'(shots_used), 32'd0);
    check("rst_ships", 32'(ships_left), 32'd0);
    check("rst_pulses", pulse_vec(), 32'd0);
    reset = 1'b1;

    // Power up, save preset 0, enter attack.
    @(negedge clock);
    on_off = 1'b1;
    repeat (2) @(negedge clock);
    m_state = 1;
    check("pwr_state", 32'(game_state), 32'd1);
    press(1);
    model_save(0);
    check("save_ships", 32'(ships_left), 32'd12);
    check("save_ships_model", 32'(ships_left), 32'(m_ships));
    status = 1'b1;
    repeat (2) @(negedge clock);
    m_state = 2;
    check("atk_state", 32'(game_state), 32'd2);
    check("atk_shots", 32'(shots_used), 32'd0);

    fire("hit00", 0, 0);
    fire("dup00", 0, 0);
    fire("inv_col", 5, 2);
    fire("inv_row", 1, 7);

    // Fresh game, then exhaust the shot budget on misses.
    press(2);
    model_restart();
    check("rg_state", 32'(game_state), 32'd1);
    check("rg_shots", 32'(shots_used), 32'd0);
    press(1);
    model_save(0);
    m_state = 2;
    check("reatk_state", 32'(game_state), 32'd2);
    foreach (miss_list[i]) fire("miss", miss_list[i] / 7, miss_list[i] % 7);
    check("lose_state", 32'(game_state), 32'd4);
    scan_check("lose_disp", m_ship);
    fire("lose_ignore", 0, 0);

    // Preset cycling with wrap, then sink the whole fleet.
    press(2);
    model_restart();
    status = 1'b0;
    repeat (3) press(0);
    scan_check("preset3", bpat(3));
    press(0);
    scan_check("preset0", bpat(0));
    press(1);
    model_save(0);
    status = 1'b1;
    repeat (2) @(negedge clock);
    m_state = 2;
    check("win_entry", 32'(game_state), 32'd2);
    for (int k = 0; k < 35; k += 3) fire("sink", k / 7, k % 7);
    check("win_state", 32'(game_state), 32'd3);
    scan_check("win_disp", {35{1'b1}});

    // Restart and attack on the same edge: restart wins.
    press(2);
    model_restart();
    press(1);
    model_save(0);
    m_state = 2;
    fire("pre_sim", 0, 3);
    model_restart();
    begin
      exp_t e;
      e.pulses = 4'b0000;
      e.shots = 0;
      e.ships = 0;
      e.state = 1;
      @(negedge clock);
      col_attack = 3'd0;
      row_attack = 3'd6;
      reset_game_btn = 1'b1;
      attack_btn = 1'b1;
      sb_q.push_back(e);
      @(negedge clock);
      sb_check("sim_rg_atk");
      reset_game_btn = 1'b0;
      attack_btn = 1'b0;
    end

    // Asynchronous reset in the middle of an attack.
    press(1);
    model_save(0);
    m_state = 2;
    fire("pre_rst", 1, 2);
    @(negedge clock);
    scan_tick = 1'b1;
    @(negedge clock);
    scan_tick = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_state", 32'(game_state), 32'd0);
    check("arst_shots", 32'(shots_used), 32'd0);
    check("arst_ships", 32'(ships_left), 32'd0);
    check("arst_cols", 32'(columns), 32'd1);
    check("arst_lines", 32'(lines), 32'd0);
    check("arst_pulses", pulse_vec(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
